// File: rtl/usr_shift_engine.sv
// Command-driven universal shift register: one accepted command performs a
// load/clear/hold or a counted sequence of shift/rotate steps, then pulses done.

module usr_shift_bit (
  input  logic [2:0] sel,
  input  logic [7:0] cand,
  output logic       y
);
  assign y = cand[sel];
endmodule

module usr_shift_engine #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_mode,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [WIDTH-1:0] par_in,
  input  logic             sin_r,
  input  logic             sin_l,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done
);
  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_CLR  = 3'b111;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic [2:0]       mode;
    logic [CNT_W-1:0] cnt;
  } cmd_t;

  state_t                  state, state_nx;
  cmd_t                    cur, cur_nx;
  logic [WIDTH-1:0]        q_nx, step_q;
  logic [2:0]              sel;
  logic [7:0][WIDTH-1:0]   cand;
  logic [WIDTH-1:0][7:0]   col;

  // One candidate next-value per mode; each bit then picks its own column.
  always_comb begin
    cand[0] = q;
    cand[1] = {sin_r, q[WIDTH-1:1]};
    cand[2] = {q[WIDTH-2:0], sin_l};
    cand[3] = par_in;
    cand[4] = {q[0], q[WIDTH-1:1]};
    cand[5] = {q[WIDTH-2:0], q[WIDTH-1]};
    cand[6] = {q[WIDTH-1], q[WIDTH-1:1]};
    cand[7] = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < 8; j++)
        col[i][j] = cand[j][i];
  end

  // Immediate ops use the incoming mode; counted steps use the latched one.
  assign sel = (state == RUN) ? cur.mode : cmd_mode;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    usr_shift_bit u_bit (
      .sel  (sel),
      .cand (col[i]),
      .y    (step_q[i])
    );
  end

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    q_nx     = q;
    case (state)
      IDLE: if (cmd_valid) begin
        cur_nx.mode = cmd_mode;
        cur_nx.cnt  = cmd_count;
        if (cmd_mode == M_HOLD || cmd_mode == M_LOAD || cmd_mode == M_CLR) begin
          q_nx       = step_q;
          cur_nx.cnt = '0;
          state_nx   = DONE;
        end else if (cmd_count == '0) begin
          state_nx = DONE;
        end else begin
          state_nx = RUN;
        end
      end
      RUN: begin
        q_nx       = step_q;
        cur_nx.cnt = cur.cnt - CNT_W'(1);
        if (cur.cnt == CNT_W'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cur   <= '0;
      q     <= '0;
    end else begin
      state <= state_nx;
      cur   <= cur_nx;
      q     <= q_nx;
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign sout_r    = q[0];
  assign sout_l    = q[WIDTH-1];
endmodule

// File: tb/tb_usr_shift_engine.sv
// Directed bench for usr_shift_engine: per-cycle comparison against a
// transaction-level model, plus literal expectations from hand calculation.

module tb_usr_shift_engine;
  logic       clk = 0;
  logic       rst = 1;
  logic       cmd_valid = 0;
  logic       cmd_ready;
  logic [2:0] cmd_mode = 0;
  logic [3:0] cmd_count = 0;
  logic [7:0] par_in = 0;
  logic       sin_r = 0, sin_l = 0;
  logic [7:0] q;
  logic       sout_r, sout_l, busy, done;

  usr_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_mode(cmd_mode), .cmd_count(cmd_count), .par_in(par_in),
    .sin_r(sin_r), .sin_l(sin_l), .q(q), .sout_r(sout_r), .sout_l(sout_l),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remaining step count and a pending-done flag describe the transaction.
  logic [7:0] m_q = 0;
  logic [2:0] m_mode = 0;
  int         m_left = 0;
  bit         m_done = 0;

  function automatic logic [7:0] mstep(logic [7:0] v, logic [2:0] md, logic sr, logic sl, logic [7:0] p);
    case (md)
      3'd1:    return (v >> 1) | (8'(sr) << 7);
      3'd2:    return (v << 1) | 8'(sl);
      3'd3:    return p;
      3'd4:    return (v >> 1) | (8'(v[0]) << 7);
      3'd5:    return (v << 1) | 8'(v[7]);
      3'd6:    return (v >> 1) | (v & 8'h80);
      3'd7:    return 8'h00;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q = 0; m_mode = 0; m_left = 0; m_done = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_q = mstep(m_q, m_mode, sin_r, sin_l, par_in);
      m_left--;
      if (m_left == 0) m_done = 1;
    end else if (cmd_valid) begin
      m_mode = cmd_mode;
      if (cmd_mode == 3'd0 || cmd_mode == 3'd3 || cmd_mode == 3'd7) begin
        m_q = mstep(m_q, cmd_mode, sin_r, sin_l, par_in);
        m_done = 1;
      end else if (cmd_count == 0) m_done = 1;
      else m_left = cmd_count;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("q", q, m_q);
      chk("sout_r", sout_r, m_q[0]);
      chk("sout_l", sout_l, m_q[7]);
      chk("busy", busy, (m_left != 0) || m_done);
      chk("done", done, m_done);
      chk("cmd_ready", cmd_ready, !((m_left != 0) || m_done));
    end
  end

  int nbusy, ndone;
  logic [7:0] qh [8];

  // Presents one command for one cycle, then observes until the engine is idle.
  task automatic run_cmd(input logic [2:0] m, input logic [3:0] c, input logic [7:0] p);
    int k;
    @(negedge clk);
    cmd_valid = 1; cmd_mode = m; cmd_count = c; par_in = p;
    @(negedge clk);
    cmd_valid = 0;
    nbusy = 0; ndone = 0; k = 0;
    while (!cmd_ready && k < 40) begin
      nbusy += busy; ndone += done;
      if (k < 8) qh[k] = q;
      @(negedge clk);
      k++;
    end
    if (k >= 40) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!cmd_ready && k < 40) begin @(negedge clk); k++; end
    if (k >= 40) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0; chk_en = 1;
    chk("reset_q", q, 8'h00);
    chk("reset_ready", cmd_ready, 1);

    // 1: load
    run_cmd(3'd3, 4'd0, 8'hA5);
    chk("load_q", qh[0], 8'hA5);
    chk("load_busy_cycles", nbusy, 1);
    chk("load_done_pulses", ndone, 1);

    // 2: logical shift right with sin_r=1
    sin_r = 1;
    run_cmd(3'd1, 4'd3, 8'h00);
    chk("lsr_step1", qh[1], 8'hD2);
    chk("lsr_step2", qh[2], 8'hE9);
    chk("lsr_step3", qh[3], 8'hF4);
    chk("lsr_busy_cycles", nbusy, 4);
    chk("lsr_done_pulses", ndone, 1);
    sin_r = 0;

    // 3: rotates and arithmetic shift
    run_cmd(3'd3, 4'd0, 8'hA5);
    run_cmd(3'd5, 4'd4, 8'h00);
    chk("rol4", q, 8'h5A);
    run_cmd(3'd3, 4'd0, 8'hA5);
    run_cmd(3'd5, 4'd9, 8'h00);
    chk("rol9", q, 8'h4B);
    chk("rol9_busy_cycles", nbusy, 10);
    run_cmd(3'd3, 4'd0, 8'h96);
    run_cmd(3'd6, 4'd2, 8'h00);
    chk("asr2", q, 8'hE5);

    // 4: zero-count rotate
    run_cmd(3'd3, 4'd0, 8'h3C);
    run_cmd(3'd4, 4'd0, 8'h00);
    chk("cnt0_q", q, 8'h3C);
    chk("cnt0_busy_cycles", nbusy, 1);
    chk("cnt0_done_pulses", ndone, 1);

    // 5a: clear command during RUN is ignored
    run_cmd(3'd3, 4'd0, 8'h81);
    @(negedge clk);
    cmd_valid = 1; cmd_mode = 3'd4; cmd_count = 4'd5;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_mode = 3'd7;
    @(negedge clk);
    cmd_valid = 0;
    wait_idle();
    chk("ignored_clear_q", q, 8'h0C);

    // 5b: reset in the second RUN cycle of a count-5 shift
    run_cmd(3'd3, 4'd0, 8'hFF);
    @(negedge clk);
    cmd_valid = 1; cmd_mode = 3'd2; cmd_count = 4'd5; sin_l = 0;
    @(negedge clk);
    cmd_valid = 0;
    @(negedge clk);
    chk("pre_reset_q", q, 8'hFE);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_q", q, 8'h00);
    chk("abort_ready", cmd_ready, 1);
    ndone = 0;
    repeat (4) begin @(negedge clk); ndone += done; end
    chk("abort_no_done", ndone, 0);

    // 6: back-to-back with cmd_valid held high
    @(negedge clk);
    cmd_valid = 1; cmd_mode = 3'd3; par_in = 8'h81;
    @(negedge clk);
    chk("b2b_first_done", done, 1);
    cmd_mode = 3'd2; cmd_count = 4'd1; sin_l = 0;
    begin
      int k = 0;
      while (!cmd_ready && k < 40) begin @(negedge clk); k++; end
      if (k >= 40) chk("b2b_timeout", 1, 0);
    end
    chk("b2b_q_before_second", q, 8'h81);
    @(negedge clk);
    cmd_valid = 0;
    chk("b2b_second_busy", busy, 1);
    wait_idle();
    chk("b2b_final_q", q, 8'h02);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
